vita_sync_aligner: RTL and testbench

Parametrised word-alignment and sync-decode stage for the VITA2000 LVDS receive path. It takes unaligned parallel words from per-lane deserializers, one sync lane and `NUM_CH` data lanes, all in the parallel clock domain. It finds the bit offset with a lock/verify/unlock state machine and decodes sync-channel control codes into per-word flags. It then emits bit-aligned data words with a valid strobe. It sits between the deserializers and the frame/line assembly logic.

---
 rtl/vita_sync_aligner.sv | 217 +++++++++++++++++++++
 tb/tb_vita_sync_aligner.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vita_sync_aligner.sv
// vita_sync_aligner: word alignment and sync-code decode for the VITA2000
// LVDS receive path. A lock/verify/unlock machine finds the bit offset on the
// sync lane. Every lane is then realigned at that offset, and the aligned sync
// word is decoded into one-hot control flags.
module vita_sync_aligner #(
  parameter int                NUM_CH       = 4,
  parameter int                WORD_W       = 8,
  parameter int                LOCK_COUNT   = 4,
  parameter int                UNLOCK_COUNT = 3,
  parameter logic [WORD_W-1:0] TRAIN_WORD   = WORD_W'(8'b11101001),
  parameter int                OFF_W        = $clog2(WORD_W)
) (
  input  logic                     par_clock,
  input  logic                     reset,
  input  logic [WORD_W-1:0]        sync_raw,
  input  logic [NUM_CH*WORD_W-1:0] data_raw,
  input  logic                     raw_valid,
  input  logic                     realign,
  output logic                     locked,
  output logic [OFF_W-1:0]         bit_offset,
  output logic [WORD_W-1:0]        sync,
  output logic [NUM_CH*WORD_W-1:0] cam_d,
  output logic                     out_valid,
  output logic                     FS,
  output logic                     FE,
  output logic                     LS,
  output logic                     LE,
  output logic                     ID,
  output logic                     BL,
  output logic                     TP,
  output logic                     IMG,
  output logic                     CRC,
  output logic                     INV,
  output logic [15:0]              err_count
);

  localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [MISS_W-1:0]          miss, miss_nxt;
  logic [OFF_W-1:0]           off_nxt;
  logic [WORD_W-1:0]          prev_sync_p0;
  logic [NUM_CH*WORD_W-1:0]   prev_data_p0;
  logic                       hist_ok;
  logic [WORD_W-1:0]          sync_al;
  logic [NUM_CH*WORD_W-1:0]   data_al;
  logic [8:0]                 al_flags;
  logic                       code_ok;
  logic                       hit;
  logic [OFF_W-1:0]           hit_k;
  logic                       vld_p0;
  logic [8:0]                 flags_nxt;
  logic                       inv_nxt;

  // Extract the word starting k bits into the {current, previous} window.
  function automatic logic [WORD_W-1:0] pick(input logic [WORD_W-1:0] cur,
                                             input logic [WORD_W-1:0] prv,
                                             input logic [OFF_W-1:0]  k);
    logic [2*WORD_W-1:0] win;
    win = {cur, prv};
    return WORD_W'(win >> k);
  endfunction

  // Map a word to {FS, FE, LS, LE, ID, BL, TP, IMG, CRC}; all zero if no code.
  function automatic logic [8:0] code_flags(input logic [WORD_W-1:0] w);
    logic [8:0] f;
    f[8] = (w == WORD_W'(8'hAA));
    f[7] = (w == WORD_W'(8'hCA));
    f[6] = (w == WORD_W'(8'h2A));
    f[5] = (w == WORD_W'(8'h4A));
    f[4] = (w == WORD_W'(8'h00));
    f[3] = (w == WORD_W'(8'h05));
    f[2] = (w == WORD_W'(8'hE9));
    f[1] = (w == WORD_W'(8'h0D));
    f[0] = (w == WORD_W'(8'h16));
    return f;
  endfunction

  // Error counter increment that sticks at full scale instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Word history: prev follows every accepted word, even during realign.
  always_ff @(posedge par_clock or posedge reset) begin
    if (reset) begin
      prev_sync_p0 <= '0;
      prev_data_p0 <= '0;
      hist_ok      <= 1'b0;
    end else if (raw_valid) begin
      prev_sync_p0 <= sync_raw;
      prev_data_p0 <= data_raw;
      hist_ok      <= 1'b1;
    end
  end

  // Realign all lanes at the latched offset and decode the sync lane.
  always_comb begin
    data_al = '0;
    sync_al = pick(sync_raw, prev_sync_p0, bit_offset);
    for (int i = 0; i < NUM_CH; i++) begin
      data_al[i*WORD_W +: WORD_W] = pick(data_raw[i*WORD_W +: WORD_W],
                                         prev_data_p0[i*WORD_W +: WORD_W], bit_offset);
    end
    al_flags = code_flags(sync_al);
    code_ok  = |al_flags;
  end

  // Training search: lowest offset whose sync candidate is the training word.
  always_comb begin
    hit   = 1'b0;
    hit_k = '0;
    for (int k = WORD_W - 1; k >= 0; k--) begin
      if (pick(sync_raw, prev_sync_p0, OFF_W'(k)) == TRAIN_WORD) begin
        hit   = 1'b1;
        hit_k = OFF_W'(k);
      end
    end
  end

  // State, counters, offset and lock flag.
  always_ff @(posedge par_clock or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      cnt        <= '0;
      miss       <= '0;
      bit_offset <= '0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      miss       <= miss_nxt;
      bit_offset <= off_nxt;
      locked     <= (state_nxt == LOCKED);
    end
  end

  // Next-state logic; realign overrides any word presented with it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    miss_nxt  = miss;
    off_nxt   = bit_offset;
    if (realign) begin
      state_nxt = SEARCH;
      cnt_nxt   = '0;
      miss_nxt  = '0;
    end else if (raw_valid) begin
      case (state)
        SEARCH: begin
          if (hist_ok && hit) begin
            off_nxt   = hit_k;
            cnt_nxt   = CNT_W'(1);
            state_nxt = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          if (code_ok) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt + CNT_W'(1) == CNT_W'(LOCK_COUNT)) state_nxt = LOCKED;
          end else begin
            cnt_nxt   = '0;
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          if (code_ok) begin
            miss_nxt = '0;
          end else if (miss + MISS_W'(1) == MISS_W'(UNLOCK_COUNT)) begin
            miss_nxt  = '0;
            state_nxt = SEARCH;
          end else begin
            miss_nxt = miss + MISS_W'(1);
          end
        end
        default: begin
          state_nxt = SEARCH;
          cnt_nxt   = '0;
          miss_nxt  = '0;
        end
      endcase
    end
  end

  // Output decode: only words evaluated in LOCKED reach the output stage.
  always_comb begin
    vld_p0    = raw_valid && !realign && (state == LOCKED);
    flags_nxt = vld_p0 ? al_flags : 9'd0;
    inv_nxt   = vld_p0 && !code_ok;
  end

  // Registered output stage: one cycle after the accepting edge.
  always_ff @(posedge par_clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      {FS, FE, LS, LE, ID, BL, TP, IMG, CRC} <= 9'd0;
      INV       <= 1'b0;
      sync      <= '0;
      cam_d     <= '0;
      err_count <= '0;
    end else begin
      out_valid <= vld_p0;
      {FS, FE, LS, LE, ID, BL, TP, IMG, CRC} <= flags_nxt;
      INV       <= inv_nxt;
      if (vld_p0) begin
        sync  <= sync_al;
        cam_d <= data_al;
      end
      if (inv_nxt) err_count <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_vita_sync_aligner.sv
// Directed bench for vita_sync_aligner: acquisition, decode, error tolerance,
// unlock/relock, realign and asynchronous reset mid-stream.
module tb_vita_sync_aligner;
  localparam int N = 4;

  localparam logic [9:0] F_FS  = 10'b1000000000;
  localparam logic [9:0] F_FE  = 10'b0100000000;
  localparam logic [9:0] F_LS  = 10'b0010000000;
  localparam logic [9:0] F_LE  = 10'b0001000000;
  localparam logic [9:0] F_ID  = 10'b0000100000;
  localparam logic [9:0] F_BL  = 10'b0000010000;
  localparam logic [9:0] F_TP  = 10'b0000001000;
  localparam logic [9:0] F_IMG = 10'b0000000100;
  localparam logic [9:0] F_CRC = 10'b0000000010;
  localparam logic [9:0] F_INV = 10'b0000000001;
  localparam logic [31:0] DLN  = 32'h13121110;

  logic        par_clock = 1'b0;
  logic        reset, raw_valid, realign;
  logic [7:0]  sync_raw;
  logic [31:0] data_raw;
  logic        locked;
  logic [2:0]  bit_offset;
  logic [7:0]  sync;
  logic [31:0] cam_d;
  logic        out_valid;
  logic        FS, FE, LS, LE, ID, BL, TP, IMG, CRC, INV;
  logic [15:0] err_count;
  logic [9:0]  flg;

  int          checks = 0;
  int          errors = 0;
  int          koff;
  logic [7:0]  pa_s;
  logic [31:0] pa_d;

  assign flg = {FS, FE, LS, LE, ID, BL, TP, IMG, CRC, INV};

  vita_sync_aligner dut (
    .par_clock(par_clock), .reset(reset), .sync_raw(sync_raw), .data_raw(data_raw),
    .raw_valid(raw_valid), .realign(realign), .locked(locked), .bit_offset(bit_offset),
    .sync(sync), .cam_d(cam_d), .out_valid(out_valid),
    .FS(FS), .FE(FE), .LS(LS), .LE(LE), .ID(ID), .BL(BL), .TP(TP), .IMG(IMG),
    .CRC(CRC), .INV(INV), .err_count(err_count)
  );

  always #5 par_clock = ~par_clock;

  // Raw word that makes the candidate at offset k equal 'last' on this push
  // and carries the low bits of 'a' for the next push.
  function automatic logic [7:0] enc(input logic [7:0] a, input logic [7:0] last, input int k);
    logic [15:0] t;
    t = ({8'h00, a} << k) | ({8'h00, last} >> (8 - k));
    return t[7:0];
  endfunction

  // One clock of stimulus; the word decoded on this edge is the previously accepted one.
  task automatic push(input logic [7:0] a, input logic [31:0] d, input logic rv, input logic ra);
    @(negedge par_clock);
    sync_raw = enc(a, pa_s, koff);
    for (int i = 0; i < N; i++) data_raw[i*8 +: 8] = enc(d[i*8 +: 8], pa_d[i*8 +: 8], koff);
    raw_valid = rv;
    realign   = ra;
    if (rv) begin
      pa_s = a;
      pa_d = d;
    end
    @(posedge par_clock);
    #1;
    raw_valid = 1'b0;
    realign   = 1'b0;
  endtask

  task automatic lock_at(input int k);
    @(negedge par_clock);
    reset = 1'b1;
    @(negedge par_clock);
    reset = 1'b0;
    koff = k;
    pa_s = 8'hE9;
    pa_d = '0;
    for (int i = 0; i < 5; i++) push(8'hE9, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({locked, bit_offset} !== {1'b1, 3'(k)}) begin
      errors++;
      $display("FAIL lock_at%0d: locked=%b offset=%0d expected locked=1 offset=%0d", k, locked, bit_offset, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; raw_valid = 1'b0; realign = 1'b0; sync_raw = '0; data_raw = '0;
    koff = 0; pa_s = '0; pa_d = '0;
    repeat (3) @(negedge par_clock);
    checks++;
    if ({locked, bit_offset, sync, cam_d, out_valid, flg, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h expected all zero", {locked, bit_offset, sync, cam_d, out_valid, flg, err_count});
    end
    reset = 1'b0;
    @(posedge par_clock);
    #1;
    checks++;
    if ({locked, bit_offset, out_valid, flg, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_release: outputs=%h expected all zero", {locked, bit_offset, out_valid, flg, err_count});
    end
  endtask

  task automatic test_lock_initial();
    koff = 3; pa_s = 8'hE9; pa_d = '0;
    for (int w = 1; w <= 6; w++) begin
      push(8'hE9, 32'h0, 1'b1, 1'b0);
      if (w == 1) begin
        checks++;
        if ({locked, bit_offset} !== 4'b0_000) begin
          errors++; $display("FAIL init_w1: locked=%b offset=%0d expected 0/0", locked, bit_offset);
        end
      end
      if (w == 2) begin
        checks++;
        if ({locked, bit_offset} !== 4'b0_011) begin
          errors++; $display("FAIL init_hit_w2: locked=%b offset=%0d expected 0/3", locked, bit_offset);
        end
      end
      if (w == 4) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++; $display("FAIL init_w4: locked=%b expected 0", locked);
        end
      end
      if (w == 5) begin
        checks++;
        if ({locked, out_valid} !== 2'b10) begin
          errors++; $display("FAIL init_lock_w5: locked=%b out_valid=%b expected 1/0", locked, out_valid);
        end
      end
      if (w == 6) begin
        checks++;
        if ({out_valid, flg, sync} !== {1'b1, F_TP, 8'hE9}) begin
          errors++; $display("FAIL init_first_out: valid=%b flags=%b sync=%h expected 1/%b/e9", out_valid, flg, sync, F_TP);
        end
      end
    end
  endtask

  task automatic test_decode();
    logic [7:0] codes [9];
    logic [9:0] expf  [9];
    codes = '{8'hAA, 8'h00, 8'h0D, 8'h4A, 8'hCA, 8'h2A, 8'h05, 8'h16, 8'hE9};
    expf  = '{F_FS, F_ID, F_IMG, F_LE, F_FE, F_LS, F_BL, F_CRC, F_TP};
    lock_at(5);
    push(codes[0], DLN, 1'b1, 1'b0);
    checks++;
    if ({out_valid, flg, sync, cam_d} !== {1'b1, F_TP, 8'hE9, 32'h0}) begin
      errors++; $display("FAIL dec_first: valid=%b flags=%b sync=%h cam_d=%h expected 1/%b/e9/0", out_valid, flg, sync, cam_d, F_TP);
    end
    for (int i = 1; i < 9; i++) begin
      push(codes[i], DLN, 1'b1, 1'b0);
      checks++;
      if ({out_valid, flg, sync, cam_d} !== {1'b1, expf[i-1], codes[i-1], DLN}) begin
        errors++;
        $display("FAIL dec_code%0d: valid=%b flags=%b sync=%h cam_d=%h expected 1/%b/%h/%h",
                 i - 1, out_valid, flg, sync, cam_d, expf[i-1], codes[i-1], DLN);
      end
    end
    push(8'hE9, DLN, 1'b0, 1'b0);
    checks++;
    if ({out_valid, flg} !== 11'd0) begin
      errors++; $display("FAIL dec_gap: valid=%b flags=%b expected 0/0", out_valid, flg);
    end
  endtask

  task automatic test_err_tolerance();
    logic [7:0]  seq  [6];
    logic [9:0]  expf [6];
    logic [15:0] expe [6];
    seq  = '{8'h11, 8'h22, 8'hE9, 8'h11, 8'h22, 8'hE9};
    expf = '{F_TP, F_INV, F_INV, F_TP, F_INV, F_INV};
    expe = '{16'd0, 16'd1, 16'd2, 16'd2, 16'd3, 16'd4};
    lock_at(3);
    for (int i = 0; i < 6; i++) begin
      push(seq[i], 32'h0, 1'b1, 1'b0);
      checks++;
      if ({locked, out_valid, flg, err_count} !== {1'b1, 1'b1, expf[i], expe[i]}) begin
        errors++;
        $display("FAIL err_step%0d: locked=%b valid=%b flags=%b err=%0d expected 1/1/%b/%0d",
                 i, locked, out_valid, flg, err_count, expf[i], expe[i]);
      end
    end
  endtask

  task automatic test_unlock_relock();
    int n;
    lock_at(3);
    push(8'h11, 32'h0, 1'b1, 1'b0);
    push(8'h11, 32'h0, 1'b1, 1'b0);
    push(8'h11, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({locked, INV, err_count} !== {1'b1, 1'b1, 16'd2}) begin
      errors++; $display("FAIL unlock_pre: locked=%b INV=%b err=%0d expected 1/1/2", locked, INV, err_count);
    end
    push(8'h11, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({locked, INV, err_count, bit_offset} !== {1'b0, 1'b1, 16'd3, 3'd3}) begin
      errors++; $display("FAIL unlock_drop: locked=%b INV=%b err=%0d offset=%0d expected 0/1/3/3", locked, INV, err_count, bit_offset);
    end
    push(8'h11, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({out_valid, flg} !== 11'd0) begin
      errors++; $display("FAIL unlock_no_out: valid=%b flags=%b expected 0/0", out_valid, flg);
    end
    koff = 6;
    n = 0;
    while (!locked && n < 20) begin
      push(8'hE9, 32'h0, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if ({locked, bit_offset} !== {1'b1, 3'd6}) begin
      errors++; $display("FAIL relock6: locked=%b offset=%0d after %0d words expected 1/6", locked, bit_offset, n);
    end
    push(8'hE9, 32'h0, 1'b1, 1'b0);
    checks++;
    if ({out_valid, flg, sync} !== {1'b1, F_TP, 8'hE9}) begin
      errors++; $display("FAIL relock_out: valid=%b flags=%b sync=%h expected 1/%b/e9", out_valid, flg, sync, F_TP);
    end
  endtask

  task automatic test_realign();
    lock_at(5);
    push(8'hE9, 32'h0, 1'b1, 1'b1);
    checks++;
    if ({locked, out_valid, flg, bit_offset} !== {1'b0, 1'b0, 10'd0, 3'd5}) begin
      errors++; $display("FAIL realign_now: locked=%b valid=%b flags=%b offset=%0d expected 0/0/0/5", locked, out_valid, flg, bit_offset);
    end
    push(8'hE9, 32'h0, 1'b0, 1'b0);
    push(8'hE9, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({locked, out_valid, bit_offset} !== {1'b0, 1'b0, 3'd5}) begin
      errors++; $display("FAIL realign_idle: locked=%b valid=%b offset=%0d expected 0/0/5", locked, out_valid, bit_offset);
    end
    for (int i = 1; i <= 4; i++) begin
      push(8'hE9, 32'h0, 1'b1, 1'b0);
      if (i == 3) begin
        checks++;
        if (locked !== 1'b0) begin
          errors++; $display("FAIL realign_relock3: locked=%b expected 0", locked);
        end
      end
      if (i == 4) begin
        checks++;
        if ({locked, bit_offset} !== {1'b1, 3'd5}) begin
          errors++; $display("FAIL realign_relock4: locked=%b offset=%0d expected 1/5", locked, bit_offset);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    int rvp [10];
    int acc;
    rvp = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 1};
    lock_at(3);
    push(8'h11, DLN, 1'b1, 1'b0);
    push(8'hAA, DLN, 1'b1, 1'b0);
    checks++;
    if ({INV, err_count, cam_d} !== {1'b1, 16'd1, DLN}) begin
      errors++; $display("FAIL mid_pre: INV=%b err=%0d cam_d=%h expected 1/1/%h", INV, err_count, cam_d, DLN);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({locked, bit_offset, sync, cam_d, out_valid, flg, err_count} !== '0) begin
      errors++;
      $display("FAIL mid_async: outputs=%h expected all zero", {locked, bit_offset, sync, cam_d, out_valid, flg, err_count});
    end
    for (int i = 0; i < 4; i++) push(8'hE9, 32'h0, 1'(rvp[i]), 1'b0);
    checks++;
    if ({locked, out_valid, bit_offset} !== 5'd0) begin
      errors++; $display("FAIL mid_held: locked=%b valid=%b offset=%0d expected 0/0/0", locked, out_valid, bit_offset);
    end
    @(negedge par_clock);
    reset = 1'b0;
    koff = 3; pa_s = 8'hE9; pa_d = '0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      push(8'hE9, 32'h0, 1'(rvp[i]), 1'b0);
      if (rvp[i] != 0) begin
        acc++;
        if (acc == 1) begin
          checks++;
          if ({locked, bit_offset} !== 4'b0_000) begin
            errors++; $display("FAIL mid_first_word: locked=%b offset=%0d expected 0/0", locked, bit_offset);
          end
        end
        if (acc == 2) begin
          checks++;
          if ({locked, bit_offset} !== 4'b0_011) begin
            errors++; $display("FAIL mid_hit: locked=%b offset=%0d expected 0/3", locked, bit_offset);
          end
        end
        if (acc == 4) begin
          checks++;
          if (locked !== 1'b0) begin
            errors++; $display("FAIL mid_acc4: locked=%b expected 0", locked);
          end
        end
        if (acc == 5) begin
          checks++;
          if ({locked, out_valid} !== 2'b10) begin
            errors++; $display("FAIL mid_lock: locked=%b valid=%b expected 1/0", locked, out_valid);
          end
        end
        if (acc == 6) begin
          checks++;
          if ({out_valid, flg, sync} !== {1'b1, F_TP, 8'hE9}) begin
            errors++; $display("FAIL mid_out: valid=%b flags=%b sync=%h expected 1/%b/e9", out_valid, flg, sync, F_TP);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_initial();
    test_decode();
    test_err_tolerance();
    test_unlock_relock();
    test_realign();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
